// File: rtl/bsg_arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package bsg_arb_pkg;

  typedef enum logic [0:0] {eIdle, eBusy} arb_state_e;

  function automatic int unsigned bsg_arb_id_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_arb_rr_pick.sv
// Combinational round-robin pick: lowest request above last_id, else lowest request overall.
module bsg_arb_rr_pick
  import bsg_arb_pkg::*;
#(
  parameter int unsigned inputs_p = 4
) (
  input  logic [inputs_p-1:0]                           reqs,
  input  logic [bsg_arb_id_width(inputs_p)-1:0]         last_id,
  output logic [inputs_p-1:0]                           grant_oh,
  output logic [bsg_arb_id_width(inputs_p)-1:0]         grant_id,
  output logic                                          any_v
);

  localparam int unsigned IdW = bsg_arb_id_width(inputs_p);

  logic [inputs_p-1:0] mask;
  logic [inputs_p-1:0] masked_reqs;
  logic [inputs_p-1:0] scan_masked;
  logic [inputs_p-1:0] scan_all;
  logic [inputs_p-1:0] scan_sel;

  always_comb begin
    mask = '0;
    for (int k = 0; k < int'(inputs_p); k++) begin
      mask[k] = (k > int'(last_id));
    end
  end

  assign masked_reqs = reqs & mask;

  bsg_scan #(
    .width_p   (inputs_p),
    .or_p      (1'b1),
    .lo_to_hi_p(1'b1)
  ) u_scan_masked (
    .i(masked_reqs),
    .o(scan_masked)
  );

  bsg_scan #(
    .width_p   (inputs_p),
    .or_p      (1'b1),
    .lo_to_hi_p(1'b1)
  ) u_scan_all (
    .i(reqs),
    .o(scan_all)
  );

  // Wrap to the unmasked scan only when nothing is pending above last_id.
  assign scan_sel = (|masked_reqs) ? scan_masked : scan_all;
  assign grant_oh = scan_sel & ~(scan_sel << 1);
  assign any_v    = |reqs;

  always_comb begin
    grant_id = '0;
    for (int k = 0; k < int'(inputs_p); k++) begin
      if (grant_oh[k]) grant_id = grant_id | IdW'(k);
    end
  end

endmodule

// File: rtl/bsg_scan.sv
// Prefix scan (OR or AND) in either direction across a vector.
module bsg_scan #(
  parameter int unsigned width_p    = 4,
  parameter bit          or_p       = 1'b1,
  parameter bit          lo_to_hi_p = 1'b1
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  always_comb begin
    o = '0;
    if (lo_to_hi_p) begin
      o[0] = i[0];
      for (int k = 1; k < int'(width_p); k++) begin
        o[k] = or_p ? (o[k-1] | i[k]) : (o[k-1] & i[k]);
      end
    end else begin
      o[width_p-1] = i[width_p-1];
      for (int k = int'(width_p) - 2; k >= 0; k--) begin
        o[k] = or_p ? (o[k+1] | i[k]) : (o[k+1] & i[k]);
      end
    end
  end

endmodule

// File: rtl/bsg_arb_rr_lock.sv
// Registered round-robin arbiter with lock/hold; BSG_ARB_RR_HOLD_LIMIT_EN bounds
// consecutive locked re-grants to hold_max_p.
module bsg_arb_rr_lock
  import bsg_arb_pkg::*;
#(
  parameter int unsigned inputs_p   = 4,
  parameter int unsigned hold_max_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [inputs_p-1:0]                   reqs_i,
  input  logic [inputs_p-1:0]                   lock_i,
  output logic                                  v_o,
  output logic [inputs_p-1:0]                   grants_o,
  output logic [bsg_arb_id_width(inputs_p)-1:0] grant_id_o,
  input  logic                                  yumi_i
);

  localparam int unsigned IdW = bsg_arb_id_width(inputs_p);

  arb_state_e          state_q, state_d;
  logic [inputs_p-1:0] grants_q, grants_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [IdW-1:0]      last_id_q, last_id_d;
  logic                hold_ok;

  logic [inputs_p-1:0] pick_oh;
  logic [IdW-1:0]      pick_id;
  logic                pick_v;

  bsg_arb_rr_pick #(
    .inputs_p(inputs_p)
  ) u_pick (
    .reqs    (reqs_i),
    .last_id (last_id_q),
    .grant_oh(pick_oh),
    .grant_id(pick_id),
    .any_v   (pick_v)
  );

`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
  localparam int unsigned HoldW = $clog2(hold_max_p + 1);
  logic [HoldW-1:0] hold_q, hold_d;
  assign hold_ok = (hold_q < HoldW'(hold_max_p));
`else
  assign hold_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    id_d      = id_q;
    last_id_d = last_id_q;
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      eIdle: begin
        if (pick_v) begin
          state_d   = eBusy;
          grants_d  = pick_oh;
          id_d      = pick_id;
          last_id_d = pick_id;
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
          hold_d    = '0;
`endif
        end
      end
      eBusy: begin
        if (yumi_i) begin
          if (lock_i[id_q] && reqs_i[id_q] && hold_ok) begin
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
            hold_d = hold_q + HoldW'(1);
`endif
          end else if (pick_v) begin
            // last_id_q equals id_q here, so the current winner ranks lowest.
            grants_d  = pick_oh;
            id_d      = pick_id;
            last_id_d = pick_id;
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
            hold_d    = '0;
`endif
          end else begin
            state_d  = eIdle;
            grants_d = '0;
            id_d     = '0;
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
            hold_d   = '0;
`endif
          end
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= eIdle;
      grants_q  <= '0;
      id_q      <= '0;
      last_id_q <= IdW'(inputs_p - 1);
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grants_q  <= grants_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign v_o        = (state_q == eBusy);
  assign grants_o   = grants_q;
  assign grant_id_o = id_q;

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_arb_rr_lock: yumi without valid");

  a_params: assert property (@(posedge clk_i)
      (inputs_p >= 2) && (inputs_p <= 32) && (hold_max_p >= 1))
    else $error("bsg_arb_rr_lock: illegal parameters");

endmodule

// File: tb/tb_bsg_arb_rr_lock.sv
// Scoreboard bench: directed plan scenarios then random traffic against a round-robin model.
module tb_bsg_arb_rr_lock;

  localparam int N       = 4;
  localparam int HoldMax = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] reqs = '0;
  logic [N-1:0] lock = '0;
  logic         yumi = 1'b0;
  logic         v;
  logic [N-1:0] grants;
  logic [1:0]   gid;

  always #5 clk = ~clk;

  bsg_arb_rr_lock #(
    .inputs_p  (N),
    .hold_max_p(HoldMax)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .reqs_i    (reqs),
    .lock_i    (lock),
    .v_o       (v),
    .grants_o  (grants),
    .grant_id_o(gid),
    .yumi_i    (yumi)
  );

  typedef struct packed {
    logic         v;
    logic [N-1:0] g;
    logic [1:0]   id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  bit m_busy = 1'b0;
  int m_id   = 0;
  int m_last = N - 1;
  int m_hold = 0;

  // Next requester after `last` going upward with wrap-around.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit rst, input logic [N-1:0] r, input logic [N-1:0] l,
                            input bit y);
    bit   keep;
    exp_t e;
    if (!rst) begin
      m_busy = 1'b0; m_id = 0; m_last = N - 1; m_hold = 0;
    end else if (!m_busy) begin
      if (r != '0) begin
        m_id = rr_pick(r, m_last); m_last = m_id; m_busy = 1'b1; m_hold = 0;
      end
    end else if (y) begin
      keep = l[m_id] && r[m_id];
`ifdef BSG_ARB_RR_HOLD_LIMIT_EN
      keep = keep && (m_hold < HoldMax);
`endif
      if (keep) begin
        m_hold++;
      end else if (r != '0) begin
        m_id = rr_pick(r, m_id); m_last = m_id; m_hold = 0;
      end else begin
        m_busy = 1'b0; m_id = 0; m_hold = 0;
      end
    end
    e.v  = m_busy;
    e.g  = m_busy ? (N'(1) << m_id) : '0;
    e.id = 2'(m_id);
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; keeps the protocol legal using the model's view of the grant.
  task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] l, input bit y);
    bit y_eff;
    logic [N-1:0] r_eff;
    y_eff = y && m_busy;
    r_eff = r;
    if (m_busy && !y_eff) r_eff[m_id] = 1'b1;
    @(negedge clk);
    reset_n = rst; reqs = r_eff; lock = l; yumi = y_eff;
    @(posedge clk);
    model_edge(rst, r_eff, l, y_eff);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (v !== e.v) begin
          fails++;
          $display("FAIL v_o at %0t: got %b expected %b", $time, v, e.v);
        end
        tests++;
        if (grants !== e.g) begin
          fails++;
          $display("FAIL grants_o at %0t: got %b expected %b", $time, grants, e.g);
        end
        if (e.v) begin
          tests++;
          if (gid !== e.id) begin
            fails++;
            $display("FAIL grant_id_o at %0t: got %0d expected %0d", $time, gid, e.id);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Scenario 1: sole pair of requests, grant held without yumi.
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    for (int i = 0; i < 6; i++) step(1, 4'b1010, '0, 0);
    // Scenario 2: full round robin with no bubble.
    step(0, '0, '0, 0);
    for (int i = 0; i < 7; i++) step(1, 4'b1111, '0, 1);
    // Scenario 3: requester 0 locks.
    step(0, '0, '0, 0);
    for (int i = 0; i < 11; i++) step(1, 4'b1111, 4'b0001, 1);
    // Scenario 4: lone streaming requester.
    step(0, '0, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'b0100, '0, 1);
    // Scenario 5: drop to idle from id 2, then wrap to id 0.
    step(1, '0, '0, 1);
    step(1, 4'b0101, '0, 0);
    step(1, 4'b0101, '0, 0);
    // Scenario 6: reset while busy with id 3.
    step(1, 4'b1000, '0, 1);
    step(1, 4'b1000, '0, 1);
    step(0, 4'b1111, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, '0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), N'($urandom), N'($urandom & $urandom),
           ($urandom_range(0, 3) != 0));
    end
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
